// File: rtl/uart_frame_packer.sv
// Packs 16-bit sample words into framed bytes (HDR0 HDR1 SEQ LEN payload CHK) for the TX FIFO.
// Define UART_PACK_CRC8_EN to use CRC-8 (poly 0x07) for CHK instead of the 8-bit modular sum.
module uart_frame_packer #(
  parameter int unsigned FRAME_SAMPLES = 16,
  parameter logic [7:0]  HDR0          = 8'hEB,
  parameter logic [7:0]  HDR1          = 8'h90
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic [7:0]  fifo_data8,
  output logic        fifo_wrreq,
  output logic        busy,
  output logic        frame_done,
  output logic        drop_pulse,
  output logic [15:0] drop_cnt
);

  localparam logic [7:0] Len     = 8'(2 * FRAME_SAMPLES);
  localparam logic [7:0] LastIdx = 8'(FRAME_SAMPLES - 1);

  typedef enum logic [2:0] {
    StIdle, StH0, StH1, StSeq, StLen, StHi, StLo, StChk
  } state_e;

  state_e      state_q;
  logic [15:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        drop;
  logic        consume;
  logic [7:0]  lo_q;
  logic [7:0]  seq_q;
  logic [7:0]  chk_q;
  logic [7:0]  idx_q;

  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_PACK_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
`else
    return acc + b;
`endif
  endfunction

  assign consume = (state_q == StHi) && hold_full_q;
  assign busy    = (state_q != StIdle);

  // One-deep hold: a new sample may replace one being consumed in the same cycle.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~consume;
    drop        = 1'b0;
    if (sample_valid && !(state_q == StIdle && !enable)) begin
      if (!hold_full_q || consume) begin
        hold_d      = sample_data;
        hold_full_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      lo_q        <= '0;
      seq_q       <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      fifo_data8  <= '0;
      fifo_wrreq  <= 1'b0;
      frame_done  <= 1'b0;
      drop_pulse  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      drop_pulse  <= drop;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      fifo_wrreq <= 1'b0;
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: if (enable && hold_full_q) state_q <= StH0;
        StH0: begin
          fifo_data8 <= HDR0;
          fifo_wrreq <= 1'b1;
          state_q    <= StH1;
        end
        StH1: begin
          fifo_data8 <= HDR1;
          fifo_wrreq <= 1'b1;
          state_q    <= StSeq;
        end
        StSeq: begin
          fifo_data8 <= seq_q;
          fifo_wrreq <= 1'b1;
          chk_q      <= chk_step(8'h00, seq_q);
          idx_q      <= '0;
          state_q    <= StLen;
        end
        StLen: begin
          fifo_data8 <= Len;
          fifo_wrreq <= 1'b1;
          chk_q      <= chk_step(chk_q, Len);
          state_q    <= StHi;
        end
        StHi: begin
          if (hold_full_q) begin
            fifo_data8 <= hold_q[15:8];
            fifo_wrreq <= 1'b1;
            lo_q       <= hold_q[7:0];
            chk_q      <= chk_step(chk_q, hold_q[15:8]);
            state_q    <= StLo;
          end
        end
        StLo: begin
          fifo_data8 <= lo_q;
          fifo_wrreq <= 1'b1;
          chk_q      <= chk_step(chk_q, lo_q);
          idx_q      <= idx_q + 8'd1;
          state_q    <= (idx_q == LastIdx) ? StChk : StHi;
        end
        StChk: begin
          fifo_data8 <= chk_q;
          fifo_wrreq <= 1'b1;
          frame_done <= 1'b1;
          seq_q      <= seq_q + 8'd1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench for uart_frame_packer with FRAME_SAMPLES=2; expected bytes are queued
// when samples are scheduled and compared on every fifo_wrreq strobe.
module tb_uart_frame_packer;

  localparam int unsigned N = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic [7:0]  fifo_data8;
  logic        fifo_wrreq;
  logic        busy;
  logic        frame_done;
  logic        drop_pulse;
  logic [15:0] drop_cnt;

  int          errors = 0;
  int          checks = 0;
  int          drop_seen = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_e;
  logic [7:0]  exp_seq = 8'h00;

  always #5 clock = ~clock;

  uart_frame_packer #(
    .FRAME_SAMPLES(N)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .fifo_data8   (fifo_data8),
    .fifo_wrreq   (fifo_wrreq),
    .busy         (busy),
    .frame_done   (frame_done),
    .drop_pulse   (drop_pulse),
    .drop_cnt     (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Checksum model: bit-serial CRC-8 or plain byte sum.
  function automatic logic [7:0] model_acc(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
`ifdef UART_PACK_CRC8_EN
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
`else
    fb = 1'b0;
    r  = c + b + {7'b0, fb};
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic push_frame(input logic [15:0] s0, input logic [15:0] s1);
    logic [7:0] c;
    logic [7:0] len;
    len = 8'(2 * N);
    push_byte(8'hEB, 1'b0);
    push_byte(8'h90, 1'b0);
    push_byte(exp_seq, 1'b0);
    push_byte(len, 1'b0);
    c = model_acc(8'h00, exp_seq);
    c = model_acc(c, len);
    push_byte(s0[15:8], 1'b0);
    c = model_acc(c, s0[15:8]);
    push_byte(s0[7:0], 1'b0);
    c = model_acc(c, s0[7:0]);
    push_byte(s1[15:8], 1'b0);
    c = model_acc(c, s1[15:8]);
    push_byte(s1[7:0], 1'b0);
    c = model_acc(c, s1[7:0]);
    push_byte(c, 1'b1);
    exp_seq = exp_seq + 8'd1;
  endtask

  // Samples spaced 8 cycles apart so the hold register is always free again.
  task automatic run_frame(input logic [15:0] s0, input logic [15:0] s1);
    push_frame(s0, s1);
    send(s0);
    repeat (7) tick();
    send(s1);
    repeat (7) tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check_eq(tag, exp_q.size(), 0);
  endtask

  always @(negedge clock) begin
    if (drop_pulse) drop_seen++;
    if (fifo_wrreq) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_byte", exp_q.size(), 1);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("byte", {24'b0, fifo_data8}, {24'b0, exp_e[7:0]});
        check_eq("frame_done", {31'b0, frame_done}, {31'b0, exp_e[8]});
      end
    end else if (frame_done) begin
      check_eq("frame_done_without_wr", {31'b0, fifo_wrreq}, 1);
    end
  end

  initial begin
    repeat (3) tick();
    check_eq("rst_wrreq", {31'b0, fifo_wrreq}, 0);
    check_eq("rst_data", {24'b0, fifo_data8}, 0);
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_done", {31'b0, frame_done}, 0);
    check_eq("rst_drop", {31'b0, drop_pulse}, 0);
    check_eq("rst_drop_cnt", {16'b0, drop_cnt}, 0);
    reset  = 1'b0;
    enable = 1'b1;

    // Basic frame (sum gives C2) and two more back-to-back frames: SEQ 00, 01, 02.
    run_frame(16'h1234, 16'hABCD);
    run_frame(16'h0001, 16'hFF00);
    run_frame(16'h8080, 16'h7F7F);
    drain("drain_basic");

    // Second sample arrives while hold is full and FSM sits in H1.
    push_frame(16'h5A5A, 16'hC3C3);
    send(16'h5A5A);
    tick();
    tick();
    send(16'hDEAD);
    check_eq("drop_pulse_hi", {31'b0, drop_pulse}, 1);
    check_eq("drop_cnt_1", {16'b0, drop_cnt}, 1);
    tick();
    check_eq("drop_pulse_lo", {31'b0, drop_pulse}, 0);
    repeat (3) tick();
    send(16'hC3C3);
    repeat (7) tick();
    drain("drain_drop");
    check_eq("drop_seen", drop_seen, 1);
    check_eq("drop_cnt_hold", {16'b0, drop_cnt}, 1);

    // Drop enable during the last PL while loading a further sample.
    push_frame(16'h1111, 16'h2222);
    send(16'h1111);
    repeat (7) tick();
    send(16'h2222);
    tick();
    enable = 1'b0;
    send(16'h3344);
    repeat (6) tick();
    check_eq("idle_after_disable", {31'b0, busy}, 0);
    repeat (4) tick();
    check_eq("still_idle", {31'b0, busy}, 0);
    drain("drain_disable");
    push_frame(16'h3344, 16'h5566);
    enable = 1'b1;
    tick();
    check_eq("reenable_h0", {31'b0, busy}, 1);
    repeat (6) tick();
    send(16'h5566);
    repeat (7) tick();
    drain("drain_reenable");

    // Run until SEQ has wrapped FF -> 00.
    do begin
      run_frame(16'($urandom), 16'($urandom));
    end while (exp_seq != 8'h01);
    drain("drain_wrap");

    // Reset right after the LN byte.
    push_byte(8'hEB, 1'b0);
    push_byte(8'h90, 1'b0);
    push_byte(exp_seq, 1'b0);
    push_byte(8'(2 * N), 1'b0);
    send(16'h9999);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_wrreq", {31'b0, fifo_wrreq}, 0);
    check_eq("midrst_data", {24'b0, fifo_data8}, 0);
    check_eq("midrst_busy", {31'b0, busy}, 0);
    check_eq("midrst_done", {31'b0, frame_done}, 0);
    check_eq("midrst_drop_cnt", {16'b0, drop_cnt}, 0);
    check_eq("midrst_sb", exp_q.size(), 0);
    reset   = 1'b0;
    exp_seq = 8'h00;
    run_frame(16'h0F0F, 16'hF0F0);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
